// File: rtl/psram_line_fetcher.sv
// Double-buffered scan-line fetcher: issues word reads to the PSRAM controller and
// serves the display from the front buffer. Optional overrun counter: PSRAM_LINE_FETCH_STATS_EN.
module psram_line_fetcher #(
  parameter int                WORDS_PER_LINE = 320,
  parameter int                ADDR_W         = 24,
  parameter int                IDX_W          = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  localparam int               CW             = $clog2(WORDS_PER_LINE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_line_start,
  input  logic [IDX_W-1:0]  i_line_index,
  input  logic [CW-1:0]     i_rd_addr,
  output logic [15:0]       o_rd_data,
  output logic              o_stb,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [15:0]       o_din,
  input  logic              i_busy,
  input  logic              i_done,
  input  logic [15:0]       i_dout,
  output logic              o_fetch_busy,
  output logic              o_overrun,
  input  logic              i_clr_overrun
`ifdef PSRAM_LINE_FETCH_STATS_EN
  , output logic [15:0]     o_overrun_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic              front;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] line_base;
  logic              swap, issue, wr_en, cnt_inc, ovr_evt, last;

  logic [15:0] bank0 [WORDS_PER_LINE];
  logic [15:0] bank1 [WORDS_PER_LINE];

  assign o_we         = 1'b0;
  assign o_din        = 16'h0000;
  assign o_fetch_busy = (state != S_IDLE);
  assign line_base    = BASE_ADDR + ADDR_W'(i_line_index) * ADDR_W'(WORDS_PER_LINE);
  assign last         = (count == CW'(WORDS_PER_LINE - 1));

  // A line start while busy abandons the current line. If the outstanding word
  // returns in that same cycle it is simply dropped and there is nothing to drain.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    issue     = 1'b0;
    wr_en     = 1'b0;
    cnt_inc   = 1'b0;
    ovr_evt   = 1'b0;
    case (state)
      S_IDLE: if (i_line_start) begin
        swap      = 1'b1;
        state_nxt = S_REQ;
      end
      S_REQ: if (i_line_start) begin
        swap    = 1'b1;
        ovr_evt = 1'b1;
      end else if (!i_busy) begin
        issue     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (i_line_start) begin
        swap      = 1'b1;
        ovr_evt   = 1'b1;
        state_nxt = i_done ? S_REQ : S_DRAIN;
      end else if (i_done) begin
        wr_en     = 1'b1;
        cnt_inc   = 1'b1;
        state_nxt = last ? S_IDLE : S_REQ;
      end
      S_DRAIN: begin
        if (i_line_start) begin
          swap    = 1'b1;
          ovr_evt = 1'b1;
        end
        if (i_done) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      front     <= 1'b0;
      count     <= '0;
      base      <= '0;
      o_stb     <= 1'b0;
      o_addr    <= '0;
      o_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      o_stb <= issue;
      if (issue) o_addr <= base + ADDR_W'(count);
      if (swap) begin
        front <= ~front;
        base  <= line_base;
        count <= '0;
      end else if (cnt_inc) begin
        count <= count + 1'b1;
      end
      if (ovr_evt)            o_overrun <= 1'b1;
      else if (i_clr_overrun) o_overrun <= 1'b0;
    end
  end

  // Back bank is the one the display is not reading: front=1 -> fill bank0.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) begin
      if (front) bank0[count] <= i_dout;
      else       bank1[count] <= i_dout;
    end
  end

  // Look ahead through a same-cycle swap so the new front shows on the next read.
  logic rd_front;
  assign rd_front = front ^ swap;

  always_ff @(posedge i_clk) begin
    if (i_rst) o_rd_data <= 16'h0000;
    else       o_rd_data <= rd_front ? bank1[i_rd_addr] : bank0[i_rd_addr];
  end

`ifdef PSRAM_LINE_FETCH_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overrun_count <= 16'h0000;
    end else if (ovr_evt) begin
      if (o_overrun_count != 16'hFFFF) o_overrun_count <= o_overrun_count + 16'h0001;
    end else if (i_clr_overrun) begin
      o_overrun_count <= 16'h0000;
    end
  end
`endif

endmodule

// File: tb/tb_psram_line_fetcher.sv
// Directed bench for psram_line_fetcher: a 4-word-line instance with a PSRAM
// responder model (data = address) plus an 8-bit-address instance for wrap.
module tb_psram_line_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [8:0]  line_index = '0;
  logic [1:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        stb, we;
  logic [23:0] addr;
  logic [15:0] din;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic [15:0] dout = '0;
  logic        fetch_busy, overrun;
  logic        clr = 1'b0;
`ifdef PSRAM_LINE_FETCH_STATS_EN
  logic [15:0] ovr_cnt;
`endif

  logic        w_line_start = 1'b0;
  logic [8:0]  w_idx = '0;
  logic [15:0] w_rd_data;
  logic        w_stb, w_we, w_fetch_busy, w_overrun;
  logic [7:0]  w_addr;
  logic [15:0] w_din;
  logic        w_done = 1'b0;
  logic [15:0] w_dout = '0;
`ifdef PSRAM_LINE_FETCH_STATS_EN
  logic [15:0] w_ovr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psram_line_fetcher #(.WORDS_PER_LINE(4), .ADDR_W(24), .IDX_W(9), .BASE_ADDR(24'h000100)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_line_start(line_start), .i_line_index(line_index),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_stb(stb), .o_we(we), .o_addr(addr),
    .o_din(din), .i_busy(busy), .i_done(done), .i_dout(dout), .o_fetch_busy(fetch_busy),
    .o_overrun(overrun), .i_clr_overrun(clr)
`ifdef PSRAM_LINE_FETCH_STATS_EN
    , .o_overrun_count(ovr_cnt)
`endif
  );

  psram_line_fetcher #(.WORDS_PER_LINE(4), .ADDR_W(8), .IDX_W(9), .BASE_ADDR(8'hFE)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_line_start(w_line_start), .i_line_index(w_idx),
    .i_rd_addr(2'd0), .o_rd_data(w_rd_data), .o_stb(w_stb), .o_we(w_we), .o_addr(w_addr),
    .o_din(w_din), .i_busy(1'b0), .i_done(w_done), .i_dout(w_dout), .o_fetch_busy(w_fetch_busy),
    .o_overrun(w_overrun), .i_clr_overrun(1'b0)
`ifdef PSRAM_LINE_FETCH_STATS_EN
    , .o_overrun_count(w_ovr_cnt)
`endif
  );

  // Responder: reply 2 cycles after each strobe with data = address; optional
  // busy window after every line start and every completion.
  logic [23:0] q[$];
  int          pend = 0, busy_left = 0, busy_cfg = 0, viol = 0;
  logic        busy_prev;
  logic [23:0] pend_addr = '0;
  bit          resp_en = 1'b1;
  logic        man_done = 1'b0;
  logic [15:0] man_dout = '0;

  always @(posedge clk) begin
    #2;
    busy_prev = busy;
    if (!resp_en) begin
      pend = 0; busy_left = 0; busy = 1'b0;
      done = man_done; dout = man_dout;
    end else begin
      done = 1'b0;
      if (busy_left > 0) busy_left--;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          done = 1'b1; dout = pend_addr[15:0]; busy_left = busy_cfg;
        end
      end
      if (line_start) busy_left = busy_cfg;
      busy = (busy_left > 0);
      if (stb) begin
        if (busy_prev) viol++;
        if (pend != 0) viol++;
        q.push_back(addr);
        pend = 2; pend_addr = addr;
      end
    end
  end

  logic [7:0] wq[$];
  int         w_pend = 0;
  logic [7:0] w_paddr = '0;

  always @(posedge clk) begin
    #2;
    w_done = 1'b0;
    if (w_pend > 0) begin
      w_pend--;
      if (w_pend == 0) begin w_done = 1'b1; w_dout = {8'h00, w_paddr}; end
    end
    if (w_stb) begin wq.push_back(w_addr); w_pend = 2; w_paddr = w_addr; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic line(input logic [8:0] idx);
    @(negedge clk); line_start = 1'b1; line_index = idx;
    @(negedge clk); line_start = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [15:0] exp);
    @(negedge clk); rd_addr = idx;
    @(negedge clk); chk($sformatf("rd[%0d]", idx), {16'h0, rd_data}, {16'h0, exp});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (fetch_busy && n < 300) begin @(negedge clk); n++; end
    chk(tag, {31'h0, fetch_busy}, 32'h0);
  endtask

  task automatic wait_q(input int sz);
    int n = 0;
    while (q.size() < sz && n < 300) begin @(negedge clk); n++; end
    chk("wait_q", q.size(), sz);
  endtask

  task automatic chk_q(input string tag, input logic [23:0] first, input int n);
    chk({tag, "_n"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++)
      chk($sformatf("%s_a%0d", tag, i), {8'h0, q[i]}, {8'h0, first + 24'(i)});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stb",   {31'h0, stb},        32'h0);
    chk("rst_addr",  {8'h0, addr},        32'h0);
    chk("rst_busy",  {31'h0, fetch_busy}, 32'h0);
    chk("rst_ovr",   {31'h0, overrun},    32'h0);
    chk("rst_rd",    {16'h0, rd_data},    32'h0);
    chk("rst_we",    {31'h0, we},         32'h0);
    chk("rst_din",   {16'h0, din},        32'h0);
`ifdef PSRAM_LINE_FETCH_STATS_EN
    chk("rst_cnt",   {16'h0, ovr_cnt},    32'h0);
`endif

    // single fetch, line 2 -> 0x108..0x10B into bank0
    q.delete(); line(9'd2); wait_idle("t1_idle");
    chk_q("t1", 24'h108, 4);
    chk("t1_ovr", {31'h0, overrun}, 32'h0);
    q.delete(); line(9'd3);
    for (int i = 0; i < 4; i++) rd(2'(i), 16'h108 + 16'(i));
    wait_idle("t1b_idle");
    chk_q("t1b", 24'h10C, 4);

    // busy backpressure, line 4 -> bank0; front now shows line 3
    busy_cfg = 5; q.delete(); line(9'd4);
    rd(2'd2, 16'h010E);
    wait_idle("t2_idle");
    chk_q("t2", 24'h110, 4);
    chk("t2_viol", viol, 0);
    busy_cfg = 0; q.delete(); line(9'd0);
    for (int i = 0; i < 4; i++) rd(2'(i), 16'h110 + 16'(i));
    wait_idle("t2b_idle");

    // overrun while word 1 of line 3 is outstanding
    q.delete(); line(9'd3);
    wait_q(2);
    line(9'd5);
    chk("t3_ovr", {31'h0, overrun}, 32'h1);
    wait_idle("t3_idle");
    chk("t3_n", q.size(), 6);
    if (q.size() == 6) begin
      chk("t3_a1", {8'h0, q[1]}, 32'h10D);
      chk("t3_a2", {8'h0, q[2]}, 32'h114);
      chk("t3_a5", {8'h0, q[5]}, 32'h117);
    end
    chk("t3_viol", viol, 0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("t3_clr", {31'h0, overrun}, 32'h0);
    q.delete(); line(9'd6);
    for (int i = 0; i < 4; i++) rd(2'(i), 16'h114 + 16'(i));
    wait_idle("t3b_idle");

    // reset while a word of line 7 is outstanding, then a late done
    q.delete(); line(9'd7);
    wait_q(1);
    @(negedge clk); resp_en = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); man_done = 1'b1; man_dout = 16'hDEAD;
    @(negedge clk); man_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_busy", {31'h0, fetch_busy}, 32'h0);
    chk("t4_stb",  {31'h0, stb},        32'h0);
    rd(2'd1, 16'h0119);
    resp_en = 1'b1; q.delete(); line(9'd0);
    rd(2'd0, 16'h0114);
    wait_idle("t4_idle");

    // back-to-back starts: 1 from idle then 3 overruns, then clear + overrun
    @(negedge clk); line_start = 1'b1; line_index = 9'd1;
    repeat (4) @(negedge clk);
    line_start = 1'b0;
    chk("t5_ovr", {31'h0, overrun}, 32'h1);
`ifdef PSRAM_LINE_FETCH_STATS_EN
    chk("t5_cnt3", {16'h0, ovr_cnt}, 32'd3);
`endif
    line_start = 1'b1; clr = 1'b1;
    @(negedge clk); line_start = 1'b0; clr = 1'b0;
    chk("t5_setwins", {31'h0, overrun}, 32'h1);
`ifdef PSRAM_LINE_FETCH_STATS_EN
    chk("t5_cnt4", {16'h0, ovr_cnt}, 32'd4);
`endif
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("t5_clr", {31'h0, overrun}, 32'h0);
`ifdef PSRAM_LINE_FETCH_STATS_EN
    chk("t5_cnt0", {16'h0, ovr_cnt}, 32'd0);
`endif
    wait_idle("t5_idle");
    chk("t5_viol", viol, 0);

    // address wrap on the 8-bit instance
    begin
      logic [7:0] exp0 [4];
      int n;
      exp0[0] = 8'hFE; exp0[1] = 8'hFF; exp0[2] = 8'h00; exp0[3] = 8'h01;
      wq.delete();
      @(negedge clk); w_line_start = 1'b1; w_idx = 9'd0;
      @(negedge clk); w_line_start = 1'b0;
      n = 0;
      while (w_fetch_busy && n < 300) begin @(negedge clk); n++; end
      chk("w0_idle", {31'h0, w_fetch_busy}, 32'h0);
      chk("w0_n", wq.size(), 4);
      for (int i = 0; i < 4 && i < wq.size(); i++)
        chk($sformatf("w0_a%0d", i), {24'h0, wq[i]}, {24'h0, exp0[i]});
      wq.delete();
      @(negedge clk); w_line_start = 1'b1; w_idx = 9'd1;
      @(negedge clk); w_line_start = 1'b0;
      n = 0;
      while (w_fetch_busy && n < 300) begin @(negedge clk); n++; end
      chk("w1_n", wq.size(), 4);
      if (wq.size() == 4) begin
        chk("w1_a0", {24'h0, wq[0]}, 32'h02);
        chk("w1_a3", {24'h0, wq[3]}, 32'h05);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
